inst_fetcher: RTL and testbench
===============================

INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameters, one per line (name, default, meaning): RESET_PC, 32'h0, first fetch address; QUEUE_DEPTH, 4, instruction-queue entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rdy  input  1  global ready; low freezes all state.
REQ-005 if_valid  output  1  registered; fetch request to the ICache.
REQ-006 pc_to_icache  output  32  registered; current fetch PC, held stable while if_valid=1.
REQ-007 inst_enable  input  1  ICache hit strobe, registered one cycle after the sampled PC.
REQ-008 inst_from_icache  input  32  instruction word qualified by inst_enable.
REQ-009 rollback  input  1  flush request from commit.
REQ-010 rollback_pc  input  32  redirect target, qualified by rollback.
REQ-011 dec_ready  input  1  decoder accepts the queue head this cycle.
REQ-012 inst_valid  output  1  queue non-empty.
REQ-013 inst_out  output  32  queue head instruction.
REQ-014 inst_pc  output  32  queue head PC.
REQ-015 inst_pred_jump  output  1  queue head was predicted taken (JAL).
REQ-016 inst_pred_pc  output  32  queue head predicted next PC.

Function
REQ-017 FSM states: FETCH (if_valid=1) and SKIP (if_valid=0); any PC change enters SKIP for exactly one cycle, then FETCH.
REQ-018 In SKIP, inst_enable and inst_from_icache are ignored, because they belong to the previous PC.
REQ-019 Accept condition: in FETCH, inst_enable=1, queue count<QUEUE_DEPTH (count sampled before any same-cycle dequeue), and rollback=0.
REQ-020 On accept, enqueue {inst_from_icache, pc, pred_jump, pred_pc}, set pc<=pred_pc, and enter SKIP.
REQ-021 Prediction: opcode inst[6:0]=7'b1101111 (JAL) gives pred_jump=1 and pred_pc=pc+sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); otherwise pred_jump=0 and pred_pc=pc+4.
REQ-022 All PC arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFFFFFC to 0 is legal.
REQ-023 Queue full with inst_enable=1: no accept; PC held; state stays FETCH; retry every cycle.
REQ-024 Dequeue: when inst_valid=1 and dec_ready=1, the head pointer advances.
REQ-025 Simultaneous enqueue and dequeue are both performed; count is unchanged.
REQ-026 Head outputs are combinational from the head entry; while inst_valid=0 they are don't-care.
REQ-027 Rollback (rdy=1) has highest priority: empty the queue, set pc<=rollback_pc, enter SKIP; any same-cycle accept or dequeue is discarded.
REQ-028 Pointers wrap modulo QUEUE_DEPTH; full and empty are distinguished by a count of width clog2(QUEUE_DEPTH)+1.
REQ-029 rdy=0: no state, pointer, PC or FSM change, and rollback is ignored; if_valid keeps its last value.
REQ-030 Minimum spacing from one accept to the next, on consecutive ICache hits, is 3 cycles.

Reset
REQ-031 rst=1, at any time including mid-miss or mid-SKIP, immediately forces: pc_to_icache=RESET_PC, FSM=SKIP, if_valid=0, queue empty, inst_valid=0.
REQ-032 After rst falls, the first edge with rdy=1 moves the FSM to FETCH and sets if_valid=1.

Verification
REQ-033 Reset release, ICache always hit with 32'h00000013 (NOP), dec_ready=1: accepted PCs are 0x0, 0x4, 0x8, each 3 cycles apart, with pred_jump=0.
REQ-034 At pc 0x100, inst 32'h0100006F (JAL +16): entry has pred_jump=1 and pred_pc=0x110; next pc_to_icache=0x110.
REQ-035 dec_ready=0 with QUEUE_DEPTH=4 hits: after 4 accepts inst_valid=1, a 5th hit is not accepted and pc is held; when dec_ready=1 for one cycle, the 5th is accepted on the next qualifying edge.
REQ-036 Rollback with rollback_pc=0x2000 asserted on the same cycle as inst_enable=1 and 2 queued entries: queue empties, no enqueue occurs, next fetch PC is 0x2000, and the stale inst_enable in the SKIP cycle is ignored.
REQ-037 rdy=0 for 5 cycles while inst_enable=1 and dec_ready=1: queue contents, count, pc and FSM are unchanged.
REQ-038 rst asserted asynchronously mid-cycle with a full queue: inst_valid=0, if_valid=0 and pc_to_icache=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetcher
//  Description : Instruction fetch stage. Issues one PC at a time to the
//                ICache, predicts JAL targets, and buffers fetched words in a
//                small circular instruction queue for the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        if_valid,
    output logic [31:0] pc_to_icache,
    input  logic        inst_enable,
    input  logic [31:0] inst_from_icache,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_pred_jump,
    output logic [31:0] inst_pred_pc
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(QUEUE_DEPTH);

    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    // SKIP: the ICache response in flight belongs to the previous PC.
    localparam logic [0:0] c_S_SKIP  = 1'b0;
    localparam logic [0:0] c_S_FETCH = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [31:0]        r_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [31:0] r_q_inst  [QUEUE_DEPTH];
    logic [31:0] r_q_pc    [QUEUE_DEPTH];
    logic        r_q_jump  [QUEUE_DEPTH];
    logic [31:0] r_q_ppc   [QUEUE_DEPTH];

    logic        w_is_jal;
    logic [31:0] w_jal_off;
    logic [31:0] w_pred_pc;
    logic        w_accept;
    logic        w_dequeue;
    logic        w_not_full;

    // Static prediction: only JAL is predicted taken, everything else falls through.
    assign w_is_jal  = (inst_from_icache[6:0] == c_OP_JAL);
    assign w_jal_off = {{11{inst_from_icache[31]}}, inst_from_icache[31],
                        inst_from_icache[19:12], inst_from_icache[20],
                        inst_from_icache[30:21], 1'b0};
    assign w_pred_pc = w_is_jal ? (r_pc + w_jal_off) : (r_pc + 32'd4);

    // Fullness uses the count as it stood before any same-cycle dequeue.
    assign w_not_full = (r_count != c_DEPTH);
    assign w_accept   = rdy && !rollback && (r_state == c_S_FETCH)
                        && inst_enable && w_not_full;
    assign w_dequeue  = rdy && !rollback && inst_valid && dec_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_SKIP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: every PC change costs exactly one SKIP cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (rdy) begin
            if (rollback) begin
                w_state_nxt = c_S_SKIP;
            end else if (r_state == c_S_SKIP) begin
                w_state_nxt = c_S_FETCH;
            end else if (w_accept) begin
                w_state_nxt = c_S_SKIP;
            end
        end
    end

    // FSM outputs: the request is decoded straight from the state flop.
    always_comb begin
        if_valid = (r_state == c_S_FETCH);
    end

    // Fetch PC: redirect wins over the sequential/predicted next PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (rdy) begin
            if (rollback) begin
                r_pc <= rollback_pc;
            end else if (w_accept) begin
                r_pc <= w_pred_pc;
            end
        end
    end

    // Queue pointers and occupancy; a flush drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (rollback) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_dequeue) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                case ({w_accept, w_dequeue})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage: written at the tail on accept; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_inst[r_tail] <= inst_from_icache;
            r_q_pc[r_tail]   <= r_pc;
            r_q_jump[r_tail] <= w_is_jal;
            r_q_ppc[r_tail]  <= w_pred_pc;
        end
    end

    assign pc_to_icache   = r_pc;
    assign inst_valid     = (r_count != '0);
    assign inst_out       = r_q_inst[r_head];
    assign inst_pc        = r_q_pc[r_head];
    assign inst_pred_jump = r_q_jump[r_head];
    assign inst_pred_pc   = r_q_ppc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetcher
//  Description : Self-checking bench for inst_fetcher. A registered ICache
//                model feeds the DUT; a queue-based reference model predicts
//                every output, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetcher;

    localparam logic [31:0] c_RESET_PC = 32'h0;
    localparam int          c_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_valid;
    logic [31:0] pc_to_icache;
    logic        inst_enable;
    logic [31:0] inst_from_icache;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_pred_jump;
    logic [31:0] inst_pred_pc;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    inst_fetcher #(
        .RESET_PC    (c_RESET_PC),
        .QUEUE_DEPTH (c_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .if_valid         (if_valid),
        .pc_to_icache     (pc_to_icache),
        .inst_enable      (inst_enable),
        .inst_from_icache (inst_from_icache),
        .rollback         (rollback),
        .rollback_pc      (rollback_pc),
        .dec_ready        (dec_ready),
        .inst_valid       (inst_valid),
        .inst_out         (inst_out),
        .inst_pc          (inst_pc),
        .inst_pred_jump   (inst_pred_jump),
        .inst_pred_pc     (inst_pred_pc)
    );

    // Program image: NOPs everywhere, a forward JAL at 0x100, backward JAL at 0x2004.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100)  return 32'h0100006F;
        if (a == 32'h2004) return 32'hFF9FF06F;
        return 32'h00000013;
    endfunction

    // ICache: always hits, answers one cycle after a sampled request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_enable      <= 1'b0;
            inst_from_icache <= 32'h0;
        end else if (rdy) begin
            inst_enable      <= if_valid;
            inst_from_icache <= mem_word(pc_to_icache);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
        logic [31:0] ppc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc    = c_RESET_PC;
    bit          m_fetch = 1'b0;

    function automatic ent_t predict(input logic [31:0] inst, input logic [31:0] pc);
        ent_t   e;
        longint off;
        e.inst = inst;
        e.pc   = pc;
        if (inst[6:0] == 7'h6F) begin
            off = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048
                + longint'(inst[19:12]) * 4096;
            if (inst[31]) off = off - 1048576;
            e.jump = 1'b1;
            e.ppc  = pc + 32'(off);
        end else begin
            e.jump = 1'b0;
            e.ppc  = pc + 32'd4;
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc    = c_RESET_PC;
            m_fetch = 1'b0;
        end else if (rdy) begin
            if (rollback) begin
                mq.delete();
                m_pc    = rollback_pc;
                m_fetch = 1'b0;
            end else begin
                bit   acc;
                bit   deq;
                ent_t e;
                acc = m_fetch && inst_enable && (mq.size() < c_DEPTH);
                deq = (mq.size() != 0) && dec_ready;
                e   = predict(inst_from_icache, m_pc);
                if (deq) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(e);
                    m_pc    = e.ppc;
                    m_fetch = 1'b0;
                end else begin
                    m_fetch = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_fetch});
        chk("pc_to_icache", pc_to_icache, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("inst_out", inst_out, mq[0].inst);
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_pred_jump", {31'b0, inst_pred_jump}, {31'b0, mq[0].jump});
            chk("inst_pred_pc", inst_pred_pc, mq[0].ppc);
        end
    end

    // Dequeue log used to pin accept order and spacing after reset.
    bit          log_en = 1'b0;
    logic [31:0] l_pc[$];
    logic        l_jmp[$];
    int          l_cyc[$];

    always @(negedge clk) begin
        if (log_en && inst_valid && dec_ready && rdy && !rollback) begin
            l_pc.push_back(inst_pc);
            l_jmp.push_back(inst_pred_jump);
            l_cyc.push_back(cyc);
        end
    end

    // Called at a negedge; holds rollback for exactly one active edge.
    task automatic do_rollback(input logic [31:0] target);
        rollback    = 1'b1;
        rollback_pc = target;
        @(negedge clk);
        rollback    = 1'b0;
    endtask

    initial begin
        bit found;
        rst         = 1'b1;
        rdy         = 1'b1;
        rollback    = 1'b0;
        rollback_pc = 32'h0;
        dec_ready   = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc", pc_to_icache, 32'h0);

        // NOP stream after reset release
        log_en = 1'b1;
        rst    = 1'b0;
        repeat (12) @(negedge clk);
        log_en = 1'b0;
        chk("nop_deq_count", {31'b0, l_pc.size() >= 3}, 32'd1);
        if (l_pc.size() >= 3) begin
            chk("nop_pc0", l_pc[0], 32'h0);
            chk("nop_pc1", l_pc[1], 32'h4);
            chk("nop_pc2", l_pc[2], 32'h8);
            chk("nop_gap01", 32'(l_cyc[1] - l_cyc[0]), 32'd3);
            chk("nop_gap12", 32'(l_cyc[2] - l_cyc[1]), 32'd3);
            chk("nop_jmp0", {31'b0, l_jmp[0]}, 32'd0);
        end

        // Forward JAL at 0x100
        dec_ready = 1'b0;
        do_rollback(32'h100);
        repeat (3) @(negedge clk);
        chk("jal_valid", {31'b0, inst_valid}, 32'd1);
        chk("jal_inst_pc", inst_pc, 32'h100);
        chk("jal_inst", inst_out, 32'h0100006F);
        chk("jal_pred_jump", {31'b0, inst_pred_jump}, 32'd1);
        chk("jal_pred_pc", inst_pred_pc, 32'h110);
        chk("jal_next_pc", pc_to_icache, 32'h110);

        // Fill the queue; the 5th hit must stall
        do_rollback(32'h40);
        repeat (15) @(negedge clk);
        chk("full_valid", {31'b0, inst_valid}, 32'd1);
        chk("full_head", inst_pc, 32'h40);
        chk("full_pc_held", pc_to_icache, 32'h50);
        chk("full_if_valid", {31'b0, if_valid}, 32'd1);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("fifth_head", inst_pc, 32'h44);
        chk("fifth_pc", pc_to_icache, 32'h54);

        // Global stall: nothing moves, rollback ignored
        rdy         = 1'b0;
        dec_ready   = 1'b1;
        rollback    = 1'b1;
        rollback_pc = 32'h999;
        repeat (5) @(negedge clk);
        chk("stall_head", inst_pc, 32'h44);
        chk("stall_pc", pc_to_icache, 32'h54);
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
        rdy       = 1'b1;
        dec_ready = 1'b0;
        rollback  = 1'b0;

        // Asynchronous reset with a full queue
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_pc", pc_to_icache, c_RESET_PC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Rollback racing an accept with two entries queued
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mq.size() == 2 && m_fetch && inst_enable) found = 1'b1;
        end
        chk("rb_setup_reached", {31'b0, found}, 32'd1);
        if (found) begin
            do_rollback(32'h2000);
            chk("rb_empty", {31'b0, inst_valid}, 32'd0);
            chk("rb_pc", pc_to_icache, 32'h2000);
            chk("rb_skip", {31'b0, if_valid}, 32'd0);
            @(negedge clk);
            chk("rb_stale_ignored", {31'b0, inst_valid}, 32'd0);
            chk("rb_fetch", {31'b0, if_valid}, 32'd1);
            repeat (2) @(negedge clk);
            chk("rb_first_pc", inst_pc, 32'h2000);
            repeat (3) @(negedge clk);
            chk("bjal_target", pc_to_icache, 32'h1FFC);
        end

        // PC wrap at the top of the address space
        do_rollback(32'hFFFFFFFC);
        repeat (3) @(negedge clk);
        chk("wrap_head", inst_pc, 32'hFFFFFFFC);
        chk("wrap_pc", pc_to_icache, 32'h0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
